// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between requesters and the priority arbiter.
// The master side is the arbiter (drives the grant), the slave side is the environment.
interface priority_arbiter_if #(
  parameter int N = 8,
  parameter int W = ($clog2(N) < 1) ? 1 : $clog2(N)
);
  logic [N-1:0] req;
  logic         mode;
  logic         grant_ready;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;

  modport master (
    input  req, mode, grant_ready,
    output grant_valid, grant_idx, grant_onehot
  );

  modport slave (
    output req, mode, grant_ready,
    input  grant_valid, grant_idx, grant_onehot
  );
endinterface

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter: fixed (MSB-first) or round-robin priority,
// valid/ready grant handshake with back-to-back grants at one per cycle.
module priority_arbiter #(
  parameter int N = 8,
  parameter int W = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input logic            clk,
  input logic            rst_n,
  priority_arbiter_if.master bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [W-1:0] LAST = W'(N - 1);

  state_t       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [W-1:0] ptr_q, ptr_d, ptr_eff;
  logic [W-1:0] winner;
  logic [N-1:0] masked;
  logic         hs;

  function automatic logic [W-1:0] msb_index(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] low_mask(input logic [W-1:0] p);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) begin
      m[i] = (i <= int'(p));
    end
    return m;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Stage p0 input side: pointer update for the accepted grant, then winner search.
  // Round-robin keeps requesters at or below ptr first; if none, wrap to the top.
  always_comb begin
    hs      = (state_q == HOLD) && bus.grant_ready;
    ptr_eff = ptr_q;
    if (hs && bus.mode) ptr_eff = (idx_q == '0) ? LAST : idx_q - W'(1);

    masked = bus.req & low_mask(ptr_eff);
    if (!bus.mode)    winner = msb_index(bus.req);
    else if (|masked) winner = msb_index(masked);
    else              winner = msb_index(bus.req);

    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_eff;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = HOLD;
          idx_d    = winner;
          onehot_d = to_onehot(winner);
        end
      end
      HOLD: begin
        if (hs) begin
          if (|bus.req) begin
            idx_d    = winner;
            onehot_d = to_onehot(winner);
          end else begin
            state_d  = IDLE;
            onehot_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

  // Stage p0 registers: every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= LAST;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.grant_valid  = (state_q == HOLD);
  assign bus.grant_idx    = idx_q;
  assign bus.grant_onehot = onehot_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter (N=8): directed scenarios plus random traffic,
// compared each cycle against a walk-the-requesters reference model.
module tb_priority_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic clk;
  logic rst_n;

  priority_arbiter_if #(.N(N), .W(W)) bus ();

  priority_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = N - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fixed: scan from the top. Round-robin: walk down from p, wrapping modulo N.
  function automatic int pick(input logic [N-1:0] r, input bit md, input int p);
    if (!md) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (p - k + N) % N;
        if (r[j]) return j;
      end
    end
    return 0;
  endfunction

  task automatic tick();
    if (!rst_n) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = N - 1;
    end else if (!m_valid) begin
      if (bus.req != '0) begin
        m_idx   = pick(bus.req, bus.mode, m_ptr);
        m_valid = 1'b1;
      end
    end else if (bus.grant_ready) begin
      if (bus.mode) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
      if (bus.req != '0) m_idx = pick(bus.req, bus.mode, m_ptr);
      else m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("model_valid",  64'(bus.grant_valid),  64'(m_valid));
    chk("model_idx",    64'(bus.grant_idx),    64'(m_idx));
    chk("model_onehot", 64'(bus.grant_onehot), m_valid ? (64'd1 << m_idx) : 64'd0);
    chk("model_ptr",    64'(dut.ptr_q),        64'(m_ptr));
  endtask

  task automatic drive(input bit rn, input logic [N-1:0] r, input bit md, input bit rdy);
    rst_n           = rn;
    bus.req         = r;
    bus.mode        = md;
    bus.grant_ready = rdy;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    chk("rst_valid",  64'(bus.grant_valid),  64'd0);
    chk("rst_idx",    64'(bus.grant_idx),    64'd0);
    chk("rst_onehot", 64'(bus.grant_onehot), 64'd0);
    chk("rst_ptr",    64'(dut.ptr_q),        64'd7);

    // Idle with no requests, ready ignored
    drive(1'b1, '0, 1'b0, 1'b1);
    tick();
    chk("idle_valid", 64'(bus.grant_valid), 64'd0);

    // Fixed priority, held request
    drive(1'b1, 8'b0010_1100, 1'b0, 1'b1);
    tick();
    chk("fix_valid",  64'(bus.grant_valid),  64'd1);
    chk("fix_idx",    64'(bus.grant_idx),    64'd5);
    chk("fix_onehot", 64'(bus.grant_onehot), 64'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fix_repeat_idx", 64'(bus.grant_idx), 64'd5);
    end

    // Backpressure while requests and mode change
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_idx",   64'(bus.grant_idx),   64'd5);
      chk("bp_valid", 64'(bus.grant_valid), 64'd1);
    end
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    tick();
    chk("bp_release_idx", 64'(bus.grant_idx), 64'd0);

    // Drain to idle, then a single-cycle request
    drive(1'b1, '0, 1'b0, 1'b1);
    tick();
    chk("drain0_valid", 64'(bus.grant_valid), 64'd0);
    drive(1'b1, 8'h08, 1'b0, 1'b1);
    tick();
    chk("pulse_idx",   64'(bus.grant_idx),   64'd3);
    chk("pulse_valid", 64'(bus.grant_valid), 64'd1);
    drive(1'b1, '0, 1'b0, 1'b1);
    tick();
    chk("drain_valid",  64'(bus.grant_valid),  64'd0);
    chk("drain_onehot", 64'(bus.grant_onehot), 64'd0);
    chk("drain_idx",    64'(bus.grant_idx),    64'd3);

    // Round-robin over all requesters
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_seq_idx",   64'(bus.grant_idx),   64'((7 - i + 8) % 8));
      chk("rr_seq_valid", 64'(bus.grant_valid), 64'd1);
    end

    // Reset while holding a grant
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h10, 1'b1, 1'b0);
    tick();
    tick();
    chk("hold4_idx", 64'(bus.grant_idx), 64'd4);
    drive(1'b0, 8'h10, 1'b1, 1'b0);
    tick();
    chk("midrst_valid", 64'(bus.grant_valid), 64'd0);
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    tick();
    chk("post_rst_idx", 64'(bus.grant_idx), 64'd7);

    // Round-robin wrap, then fixed mode with the same requests
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 8'b1000_0001, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap_idx", 64'(bus.grant_idx), (i % 2 == 0) ? 64'd7 : 64'd0);
    end
    chk("wrap_ptr", 64'(dut.ptr_q), 64'd6);
    drive(1'b1, 8'b1000_0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fix81_idx", 64'(bus.grant_idx), 64'd7);
    end
    chk("fix81_ptr", 64'(dut.ptr_q), 64'd6);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n           = ($urandom_range(0, 39) != 0);
      bus.req         = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
      bus.grant_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
